// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the 8-digit seven-segment scanner:
//                digit count, all-off pattern and the hex segment map.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   // Active-low blank pattern: every segment and the decimal point off.
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Hex glyphs, active-low, bit order {dp,g,f,e,d,c,b,a}; dp always off.
   // Entry 15 sits in the most-significant byte, entry 0 in the least.
   localparam logic [15:0][7:0] SEG_LUT = {
      8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
      8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
      8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
      8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
   };

   // Nibble to active-low segment pattern.
   function automatic logic [7:0] seg_of(input logic [3:0] nib);
      return SEG_LUT[nib];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational hex nibble to active-low seven-segment pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] segments
);

   // Pure table lookup; dp bit comes out of the table as 1 (off).
   always_comb begin
      segments = seg_of(nibble);
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scanner
//  Description : Time-multiplexes a 32-bit value as 8 hex digits onto a
//                common-anode display. Writes are shadowed and only become
//                visible at a frame boundary so no frame mixes two values.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scanner
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int BLANK_LZ = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        disp_we,
   input  logic [31:0] disp_data,
   output logic [7:0]  digitalLocation,
   output logic [7:0]  digitalStates
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [31:0]      shadow;
   logic             pending;
   logic [31:0]      shown;

   logic             tick;
   logic             frame_wrap;
   logic [3:0]       cur_nibble;
   logic [7:0]       cur_seg;
   logic [7:0]       lz_blank;
   logic             cur_blank;

   assign tick       = (cnt == CNT_LAST);
   assign frame_wrap = tick && (idx == IDX_LAST);

   // Prescaler: one digit slot every SCAN_DIV cycles.
   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CNT_W'(1);
   end

   // Digit index advances on each slot boundary and wraps 7 -> 0.
   always_ff @(posedge clk) begin
      if (rst)       idx <= '0;
      else if (tick) idx <= idx + 3'd1;
   end

   // Shadow capture and frame-boundary commit. A write in the commit cycle
   // is ordered after the commit so the older shadow is what gets shown and
   // the new value stays pending for the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow  <= '0;
         pending <= 1'b0;
         shown   <= '0;
      end else begin
         if (frame_wrap && pending) begin
            shown   <= shadow;
            pending <= 1'b0;
         end
         if (disp_we) begin
            shadow  <= disp_data;
            pending <= 1'b1;
         end
      end
   end

   // Leading-zero detection per digit; digit 0 is never blanked.
   assign lz_blank[0] = 1'b0;
   generate
      for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
         assign lz_blank[i] = (BLANK_LZ != 0) && (shown[31:4*i] == '0);
      end
   endgenerate

   assign cur_blank  = lz_blank[idx];
   assign cur_nibble = shown[{idx, 2'b00} +: 4];

   seg7_decode u_decode (
      .nibble   (cur_nibble),
      .segments (cur_seg)
   );

   // Registered outputs; at most one anode is driven low at any time.
   always_ff @(posedge clk) begin
      if (rst) begin
         digitalLocation <= SEG_OFF;
         digitalStates   <= SEG_OFF;
      end else if (cur_blank) begin
         digitalLocation <= SEG_OFF;
         digitalStates   <= SEG_OFF;
      end else begin
         digitalLocation <= ~(8'b1 << idx);
         digitalStates   <= cur_seg;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scanner
//  Description : Self-checking bench for seg7_scanner. Two instances (with and
//                without leading-zero blanking) share stimulus and are checked
//                every cycle against a time-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scanner;

   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        disp_we = 1'b0;
   logic [31:0] disp_data = '0;
   logic [7:0]  loc_lz, seg_lz, loc_nb, seg_nb;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg7_scanner #(.SCAN_DIV(DIV), .BLANK_LZ(1)) dut (
      .clk(clk), .rst(rst), .disp_we(disp_we), .disp_data(disp_data),
      .digitalLocation(loc_lz), .digitalStates(seg_lz));

   seg7_scanner #(.SCAN_DIV(DIV), .BLANK_LZ(0)) dut_nb (
      .clk(clk), .rst(rst), .disp_we(disp_we), .disp_data(disp_data),
      .digitalLocation(loc_nb), .digitalStates(seg_nb));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Glyph table written out from the hex segment map.
   function automatic logic [7:0] glyph(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
        12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   // Time since reset decides which digit is being shown; a frame ends on the
   // last cycle of every 8*DIV-cycle window.
   int          m_cyc;
   logic [31:0] m_shadow, m_shown;
   bit          m_pending;
   bit          m_valid = 0;
   logic [7:0]  e_loc_lz, e_seg_lz, e_loc_nb, e_seg_nb;

   function automatic void expect_digit(input int slot, input logic [31:0] val, input bit blz,
                                        output logic [7:0] l, output logic [7:0] s);
      bit blank;
      blank = blz && slot != 0 && ((val >> (4 * slot)) == 0);
      if (blank) begin
         l = 8'hFF; s = 8'hFF;
      end else begin
         l = 8'hFF ^ 8'(1 << slot);
         s = glyph(int'((val >> (4 * slot)) & 32'hF));
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cyc = 0; m_shadow = 0; m_shown = 0; m_pending = 0; m_valid = 1;
         e_loc_lz = 8'hFF; e_seg_lz = 8'hFF; e_loc_nb = 8'hFF; e_seg_nb = 8'hFF;
      end else if (m_valid) begin
         expect_digit((m_cyc / DIV) % 8, m_shown, 1'b1, e_loc_lz, e_seg_lz);
         expect_digit((m_cyc / DIV) % 8, m_shown, 1'b0, e_loc_nb, e_seg_nb);
         if ((m_cyc % FRAME) == FRAME - 1 && m_pending) begin
            m_shown = m_shadow;
            m_pending = 0;
         end
         if (disp_we) begin
            m_shadow = disp_data;
            m_pending = 1;
         end
         m_cyc++;
      end
   end

   // Per-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("loc_lz", loc_lz, e_loc_lz);
         chk("seg_lz", seg_lz, e_seg_lz);
         chk("loc_nb", loc_nb, e_loc_nb);
         chk("seg_nb", seg_nb, e_seg_nb);
         chk("one_anode", 32'($countones(~loc_lz) <= 1), 32'd1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b0; disp_we = 1'b0;
      end
   endtask

   task automatic write(input logic [31:0] d);
      @(negedge clk);
      rst = 1'b0; disp_we = 1'b1; disp_data = d;
   endtask

   // Wait (bounded) until the upcoming posedge is cycle k of the frame.
   task automatic wait_phase(input int k);
      int n;
      n = 0;
      @(negedge clk);
      rst = 1'b0; disp_we = 1'b0;
      while ((m_cyc % FRAME) != k && n < 2 * FRAME) begin
         @(negedge clk);
         disp_we = 1'b0;
         n++;
      end
      chk("phase_reached", 32'(n < 2 * FRAME), 32'd1);
   endtask

   initial begin
      // 1. reset held three cycles
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_loc", loc_lz, 32'hFF);
      chk("rst_seg", seg_lz, 32'hFF);
      idle(1);
      @(negedge clk);
      chk("post_rst_loc0", loc_lz, 32'hFE);
      chk("post_rst_seg0", seg_lz, 32'hC0);
      idle(FRAME + 4);

      // 2. full-width value written mid-frame
      wait_phase(10);
      write(32'h1234ABCD);
      idle(2 * FRAME + 8);

      // 3. leading zeros
      write(32'h0000_00F0);
      idle(2 * FRAME + 8);

      // 4. write landing on the commit cycle
      wait_phase(5);
      write(32'h11111111);
      wait_phase(FRAME - 2);
      write(32'h22222222);
      idle(3 * FRAME);

      // 5. back-to-back writes: only the last survives
      wait_phase(3);
      write(32'h5); write(32'h6); write(32'h7);
      idle(2 * FRAME + 8);

      // 6. reset during digit 3 with a pending update
      wait_phase(2);
      write(32'hDEAD_BEEF);
      wait_phase(3 * DIV + 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_loc", loc_lz, 32'hFF);
      chk("mid_rst_seg", seg_lz, 32'hFF);
      idle(2 * FRAME + 8);

      // Randomized phase
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 599) == 0);
         disp_we   = ($urandom_range(0, 24) == 0);
         disp_data = $urandom >> (4 * $urandom_range(0, 8));
      end
      idle(2 * FRAME);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
